// File: rtl/laser_frame_receiver_if.sv
// Byte-stream interface between the laser frame receiver and its FTDI-side consumer.
// The receiver takes the slave view. The controller or a testbench takes the master
// view: it drives the enable and the raw photodiode level, and it reads back the
// recovered bytes and the status.
interface laser_frame_receiver_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic             laser_rx;
  logic [7:0]       data_in;
  logic             data_valid;
  logic             framing_error;
  logic             busy;
  logic [CNT_W-1:0] byte_count;
  logic [7:0]       error_count;

  modport master (
    output en, laser_rx,
    input  data_in, data_valid, framing_error, busy, byte_count, error_count
  );

  modport slave (
    input  en, laser_rx,
    output data_in, data_valid, framing_error, busy, byte_count, error_count
  );
endinterface

// File: rtl/laser_frame_receiver.sv
// Laser frame receiver. It recovers 10-bit frames from an oversampled photodiode
// level. A frame is an idle 0, a start 1, 8 data bits sent LSB first, and a stop 0.
// Each bit is decided by a 3-sample majority around the middle of the bit. Frames
// with a false start are dropped silently. A bad stop bit is reported as a
// framing error.
module laser_frame_receiver #(
  parameter int OVERSAMPLE  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  laser_frame_receiver_if.slave  rx_if
);

  localparam int MID  = OVERSAMPLE / 2;
  localparam int SC_W = $clog2(OVERSAMPLE);

  localparam logic [SC_W-1:0] SAMP_ONE  = SC_W'(1);
  localparam logic [SC_W-1:0] SAMP_DEC  = SC_W'(MID + 1);
  localparam logic [SC_W-1:0] SAMP_LAST = SC_W'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [1:0]             hist_q;
  logic                   rx_s;
  logic                   maj;

  state_e           state_q;
  logic             armed_q;
  logic [SC_W-1:0]  sample_cnt_q;
  logic [SC_W-1:0]  sample_cnt_d;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       data_in_q;
  logic             data_valid_q;
  logic             framing_error_q;
  logic             busy_q;
  logic [CNT_W-1:0] byte_count_q;
  logic [7:0]       error_count_q;
  logic [7:0]       error_count_d;
  logic             at_decision;
  logic             at_wrap;

  assign rx_s = sync_q[SYNC_STAGES-1];

  // hist_q[1] holds the sample taken at MID-1 and hist_q[0] the one at MID, so the
  // vote is ready in the same cycle as the sample at MID+1.
  assign maj = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);

  assign at_decision   = (sample_cnt_q == SAMP_DEC);
  assign at_wrap       = (sample_cnt_q == SAMP_LAST);
  assign sample_cnt_d  = at_wrap ? '0 : sample_cnt_q + SAMP_ONE;
  assign error_count_d = (error_count_q == 8'hFF) ? 8'hFF : error_count_q + 8'd1;

  // Metastability synchroniser for the asynchronous pin, plus a two-deep history of rx_s for the vote
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage take the old value of the
      // stage before it. Blocking assignments here would collapse the chain into
      // one flop.
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_if.laser_rx};
      hist_q <= {hist_q[0], rx_s};
    end
  end

  // Frame FSM: bit timing, data shift, byte/error reporting and counters, all registered
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      armed_q         <= 1'b0;
      sample_cnt_q    <= '0;
      bit_idx_q       <= '0;
      // NOTE: the data registers are reset along with the control state, so every
      // output reads a defined 0 from the first cycle after reset.
      shift_q         <= '0;
      data_in_q       <= '0;
      data_valid_q    <= 1'b0;
      framing_error_q <= 1'b0;
      busy_q          <= 1'b0;
      byte_count_q    <= '0;
      error_count_q   <= '0;
    end else begin
      // NOTE: the pulse outputs are cleared by default, and only the stop-bit
      // decision sets them, so each pulse lasts exactly one cycle.
      data_valid_q    <= 1'b0;
      framing_error_q <= 1'b0;

      if (!rx_if.en) begin
        state_q      <= IDLE;
        busy_q       <= 1'b0;
        armed_q      <= 1'b0;
        sample_cnt_q <= '0;
        bit_idx_q    <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            sample_cnt_q <= '0;
            bit_idx_q    <= '0;
            if (armed_q && rx_s) begin
              // This cycle is sample 0 of the start bit.
              state_q      <= START;
              busy_q       <= 1'b1;
              armed_q      <= 1'b0;
              sample_cnt_q <= SAMP_ONE;
            end else if (!rx_s) begin
              armed_q <= 1'b1;
            end
          end

          START: begin
            sample_cnt_q <= sample_cnt_d;
            if (at_decision && !maj) begin
              state_q      <= IDLE;
              busy_q       <= 1'b0;
              sample_cnt_q <= '0;
            end else if (at_wrap) begin
              state_q   <= DATA;
              bit_idx_q <= '0;
            end
          end

          DATA: begin
            sample_cnt_q <= sample_cnt_d;
            if (at_decision) begin
              shift_q[bit_idx_q] <= maj;
            end
            if (at_wrap) begin
              if (bit_idx_q == 3'd7) begin
                state_q <= STOP;
              end else begin
                bit_idx_q <= bit_idx_q + 3'd1;
              end
            end
          end

          STOP: begin
            sample_cnt_q <= sample_cnt_d;
            if (at_decision) begin
              // Going back to IDLE this early lets a back-to-back start edge be caught.
              state_q      <= IDLE;
              busy_q       <= 1'b0;
              armed_q      <= 1'b0;
              sample_cnt_q <= '0;
              if (!maj) begin
                data_in_q    <= shift_q;
                data_valid_q <= 1'b1;
                byte_count_q <= byte_count_q + CNT_W'(1);
              end else begin
                framing_error_q <= 1'b1;
                error_count_q   <= error_count_d;
              end
            end
          end

          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            armed_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rx_if.data_in       = data_in_q;
  assign rx_if.data_valid    = data_valid_q;
  assign rx_if.framing_error = framing_error_q;
  assign rx_if.busy          = busy_q;
  assign rx_if.byte_count    = byte_count_q;
  assign rx_if.error_count   = error_count_q;

endmodule

// File: tb/tb_laser_frame_receiver.sv
// Testbench for laser_frame_receiver. A frame-level model predicts every
// data_valid/framing_error pulse. Each prediction carries its payload, its counter
// values and its arrival cycle. A monitor matches every pulse the DUT produces
// against these predictions.
module tb_laser_frame_receiver;

  localparam int OS   = 8;
  localparam int SYNC = 2;
  localparam int CW   = 16;
  // Cycles from the start edge at the pin to the data_valid pulse.
  localparam int LAT  = 9 * OS + OS / 2 + 2 + SYNC;

  logic clock = 1'b0;
  logic reset;

  always #10 clock = ~clock;

  laser_frame_receiver_if #(.CNT_W(CW)) rx_if ();

  laser_frame_receiver #(
    .OVERSAMPLE (OS),
    .SYNC_STAGES(SYNC),
    .CNT_W      (CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .rx_if(rx_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Free-running cycle count, stable whenever it is read on a falling edge.
  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- frame-level reference model ----------------
  typedef struct {
    logic        err;
    logic [7:0]  data;
    int unsigned cyc;
    logic [15:0] bc;
    logic [7:0]  ec;
  } ev_t;

  ev_t         exp_q[$];
  logic [15:0] m_bc   = '0;
  int          m_ec   = 0;
  logic [7:0]  m_data = '0;

  task automatic model_frame(input logic [7:0] b, input logic stop_hi, input int unsigned t0);
    ev_t e;
    if (!stop_hi) begin
      m_bc   = m_bc + 16'd1;
      m_data = b;
      e.err  = 1'b0;
    end else begin
      if (m_ec < 255) m_ec++;
      e.err = 1'b1;
    end
    e.data = m_data;
    e.cyc  = t0 + LAT;
    e.bc   = m_bc;
    e.ec   = m_ec[7:0];
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  ev_t  mon_e;
  logic prev_pulse = 1'b0;

  always @(negedge clock) begin
    if (rx_if.data_valid || rx_if.framing_error) begin
      check("pulse_exclusive", {31'b0, rx_if.data_valid & rx_if.framing_error}, 32'd0);
      check("pulse_one_cycle", {31'b0, prev_pulse}, 32'd0);
      check("pulse_expected", {31'b0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("pulse_kind_is_error", {31'b0, rx_if.framing_error}, {31'b0, mon_e.err});
        check("data_in", {24'b0, rx_if.data_in}, {24'b0, mon_e.data});
        check("pulse_cycle", cyc, mon_e.cyc);
        check("byte_count", {16'b0, rx_if.byte_count}, {16'b0, mon_e.bc});
        check("error_count", {24'b0, rx_if.error_count}, {24'b0, mon_e.ec});
      end
    end
    prev_pulse = rx_if.data_valid | rx_if.framing_error;
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v);
    rx_if.laser_rx = v;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0);
  endtask

  // Sends a full frame and predicts its outcome. Bit gbit, sample gsamp is inverted
  // at the pin (gbit = -1 sends no glitch).
  task automatic send_frame(input logic [7:0] b, input logic stop_hi, input int gbit, input int gsamp);
    logic [9:0] bits;
    bits = {stop_hi, b, 1'b1};
    model_frame(b, stop_hi, cyc);
    for (int i = 0; i < 10; i++)
      for (int s = 0; s < OS; s++)
        drive(bits[i] ^ (i == gbit && s == gsamp));
  endtask

  // Sends only the first n cycles of a frame. The model expects no outcome.
  task automatic send_partial(input logic [7:0] b, input int n);
    logic [9:0] bits;
    bits = {1'b0, b, 1'b1};
    for (int k = 0; k < n; k++) drive(bits[k / OS]);
  endtask

  task automatic check_rest(input string tag, input logic [7:0] d, input logic [15:0] bc, input logic [7:0] ec);
    check({tag, "_data_in"}, {24'b0, rx_if.data_in}, {24'b0, d});
    check({tag, "_byte_count"}, {16'b0, rx_if.byte_count}, {16'b0, bc});
    check({tag, "_error_count"}, {24'b0, rx_if.error_count}, {24'b0, ec});
    check({tag, "_busy"}, {31'b0, rx_if.busy}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data_in"}, {24'b0, rx_if.data_in}, 32'd0);
    check({tag, "_data_valid"}, {31'b0, rx_if.data_valid}, 32'd0);
    check({tag, "_framing_error"}, {31'b0, rx_if.framing_error}, 32'd0);
    check({tag, "_busy"}, {31'b0, rx_if.busy}, 32'd0);
    check({tag, "_byte_count"}, {16'b0, rx_if.byte_count}, 32'd0);
    check({tag, "_error_count"}, {24'b0, rx_if.error_count}, 32'd0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [7:0]  data;
    logic        stop_hi;
    int          gbit;
    int          gsamp;
    int          gap;
    logic [7:0]  exp_data;
    logic [15:0] exp_bc;
    logic [7:0]  exp_ec;
  } vec_t;

  vec_t vecs[7];

  initial begin
    // Rows: plain frame; a majority-corrected glitch at sample MID of data bit 2
    // (frame bit 3); a bad stop bit; recovery after it; then three back-to-back frames.
    vecs[0] = '{8'hA5, 1'b0, -1, -1, 20, 8'hA5, 16'd1, 8'd0};
    vecs[1] = '{8'h0F, 1'b0,  3, OS / 2, 20, 8'h0F, 16'd2, 8'd0};
    vecs[2] = '{8'h3C, 1'b1, -1, -1, 20, 8'h0F, 16'd2, 8'd1};
    vecs[3] = '{8'h11, 1'b0, -1, -1, 20, 8'h11, 16'd3, 8'd1};
    vecs[4] = '{8'h00, 1'b0, -1, -1,  0, 8'h00, 16'd4, 8'd1};
    vecs[5] = '{8'hFF, 1'b0, -1, -1,  0, 8'hFF, 16'd5, 8'd1};
    vecs[6] = '{8'h55, 1'b0, -1, -1, 20, 8'h55, 16'd6, 8'd1};

    reset          = 1'b0;
    rx_if.en       = 1'b1;
    rx_if.laser_rx = 1'b0;
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b1;
    idle(10);

    for (int v = 0; v < 7; v++) begin
      send_frame(vecs[v].data, vecs[v].stop_hi, vecs[v].gbit, vecs[v].gsamp);
      idle(vecs[v].gap);
      check_rest($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_bc, vecs[v].exp_ec);
    end

    // A 3-cycle glitch is a false start. busy is high from sample 0 until the vote
    // at MID+1, and low again by sample MID+2.
    for (int k = 0; k < 40; k++) begin
      drive(k < 3);
      if (k == 2)          check("glitch_busy_early", {31'b0, rx_if.busy}, 32'd1);
      if (k == OS / 2 + 2) check("glitch_busy_held", {31'b0, rx_if.busy}, 32'd1);
      if (k == OS / 2 + 3) check("glitch_busy_clear", {31'b0, rx_if.busy}, 32'd0);
    end
    check_rest("glitch", 8'h55, 16'd6, 8'd1);

    // Reset in the middle of the DATA bits, then a fresh frame.
    send_partial(8'h99, 40);
    reset          = 1'b0;
    rx_if.laser_rx = 1'b0;
    @(negedge clock);
    check_all_zero("mid_reset");
    m_bc   = '0;
    m_ec   = 0;
    m_data = '0;
    exp_q.delete();
    @(negedge clock);
    reset = 1'b1;
    idle(5);
    send_frame(8'h7E, 1'b0, -1, -1);
    idle(20);
    check_rest("after_reset", 8'h7E, 16'd1, 8'd0);

    // Dropping en mid-frame aborts the frame. Reception then resumes normally.
    send_partial(8'h66, 45);
    rx_if.en = 1'b0;
    drive(1'b0);
    check("en_low_busy", {31'b0, rx_if.busy}, 32'd0);
    idle(5);
    rx_if.en = 1'b1;
    idle(10);
    check_rest("en_abort", 8'h7E, 16'd1, 8'd0);
    send_frame(8'h42, 1'b0, -1, -1);
    idle(20);
    check_rest("en_resume", 8'h42, 16'd2, 8'd0);

    // Randomised traffic: random bytes and gaps (including back-to-back frames),
    // occasional bad stop bits, and single-sample glitches in the data bits.
    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      logic       sh;
      int         gb;
      int         gs;
      int         gap;
      b   = 8'($urandom_range(0, 255));
      sh  = ($urandom_range(0, 5) == 0);
      gb  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : -1;
      gs  = int'($urandom_range(0, OS - 1));
      gap = int'($urandom_range(sh ? 1 : 0, 12));
      send_frame(b, sh, gb, gs);
      idle(gap);
    end
    idle(20);
    check_rest("random", m_data, m_bc, m_ec[7:0]);

    // error_count saturates at 8'hFF.
    for (int n = 0; n < 260; n++) begin
      send_frame(8'($urandom_range(0, 255)), 1'b1, -1, -1);
      idle(1);
    end
    idle(20);
    check_rest("saturate", m_data, m_bc, 8'hFF);

    idle(LAT + 20);
    check("all_pulses_seen", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
